// File: rtl/act_buf_pkg.sv
// act_buf_pkg: shared bank-state type, default sizes and the write-path ReLU clamp used by act_pingpong_buffer.
package act_buf_pkg;

    typedef enum logic {BANK_EMPTY = 1'b0, BANK_FULL = 1'b1} bank_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 64;
    localparam int DEF_ADDR_W = 16;
    localparam int MAX_W      = 64;

    // Callers widen the word to MAX_W and pass its own sign bit, so any DATA_W <= MAX_W works.
    function automatic logic [MAX_W-1:0] relu_clamp(input logic [MAX_W-1:0] w, input logic neg);
        return neg ? '0 : w;
    endfunction

endpackage

// File: rtl/act_buf_bank.sv
// act_buf_bank: one activation bank with synchronous write and registered read; contents are never reset.
module act_buf_bank #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/act_pingpong_buffer.sv
// act_pingpong_buffer: double-buffered activation memory with commit/release bank swapping.
// Define ACT_BUF_RELU_EN to clamp negative words to zero on the write path.
module act_pingpong_buffer
    import act_buf_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int ADDR_W = DEF_ADDR_W,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_done,
    output logic              rd_avail,
    output logic              err_oob
);

    bank_state_e       st_q [2];
    bank_state_e       st_d [2];
    logic              wb_q, wb_d, rb_q, rb_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_zero_q, rd_zero_d;
    logic              rd_sel_q, rd_sel_d;
    logic              err_q, err_d;
    logic              wr_acc, rd_acc, wr_in, rd_in, commit, release_b;
    logic [1:0]        bank_we, bank_re;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] bank_rdata [2];

    always_comb begin
        wr_ready  = st_q[wb_q] == BANK_EMPTY;
        rd_avail  = st_q[rb_q] == BANK_FULL;
        wr_acc    = wr_en && wr_ready;
        rd_acc    = rd_en && rd_avail;
        wr_in     = 32'(wr_addr) < DEPTH;
        rd_in     = 32'(rd_addr) < DEPTH;
        commit    = wr_acc && wr_last;
        release_b = rd_done && rd_avail;
        bank_we   = {wr_acc && wr_in && wb_q, wr_acc && wr_in && !wb_q};
        bank_re   = {rd_acc && rd_in && rb_q, rd_acc && rd_in && !rb_q};
`ifdef ACT_BUF_RELU_EN
        wdata     = DATA_W'(relu_clamp(MAX_W'(wr_data), wr_data[DATA_W-1]));
`else
        wdata     = wr_data;
`endif
        st_d      = st_q;
        // Commit and release never hit the same bank, so both updates can land together.
        if (commit) st_d[wb_q] = BANK_FULL;
        if (release_b) st_d[rb_q] = BANK_EMPTY;
        wb_d       = wb_q ^ commit;
        rb_d       = rb_q ^ release_b;
        rd_valid_d = rd_acc;
        rd_zero_d  = rd_acc ? !rd_in : rd_zero_q;
        rd_sel_d   = rd_acc ? rb_q : rd_sel_q;
        err_d      = (wr_acc && !wr_in) || (rd_acc && !rd_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q[0]    <= BANK_EMPTY;
            st_q[1]    <= BANK_EMPTY;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
            rd_sel_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            st_q       <= st_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            rd_valid_q <= rd_valid_d;
            rd_zero_q  <= rd_zero_d;
            rd_sel_q   <= rd_sel_d;
            err_q      <= err_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        act_buf_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (wr_addr[AW-1:0]),
            .wdata (wdata),
            .re    (bank_re[b]),
            .raddr (rd_addr[AW-1:0]),
            .rdata (bank_rdata[b])
        );
    end

    // Bank read registers only move on accepted reads, so the selected one holds while idle.
    assign rd_data  = rd_zero_q ? '0 : bank_rdata[rd_sel_q];
    assign rd_valid = rd_valid_q;
    assign err_oob  = err_q;

endmodule

// File: tb/tb_act_pingpong_buffer.sv
// tb_act_pingpong_buffer: directed and randomized checks of act_pingpong_buffer against a queue-based model.
module tb_act_pingpong_buffer;

    localparam int DW = 32;
    localparam int DP = 64;
    localparam int AWD = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en, wr_last, rd_en, rd_done;
    logic [AWD-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready, rd_valid, rd_avail, err_oob;
    logic [DW-1:0] rd_data;

    act_pingpong_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_done(rd_done), .rd_avail(rd_avail), .err_oob(err_oob)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: physical word storage, a FIFO of full banks (oldest is the read bank), and the next write bank.
    logic [DW-1:0] mem [2][DP];
    bit            known [2][DP];
    int            fullq [$];
    bit            wbank;
    bit            exp_valid, exp_err, exp_known;
    logic [DW-1:0] exp_data;

    function automatic logic [DW-1:0] relu_m(input logic [DW-1:0] d);
`ifdef ACT_BUF_RELU_EN
        return (d >= 32'h8000_0000) ? 32'd0 : d;
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        fullq.delete();
        wbank = 0;
        exp_valid = 0; exp_err = 0; exp_known = 1; exp_data = '0;
    endtask

    task automatic model_step();
        bit ready, avail;
        int rbk;
        ready = fullq.size() < 2;
        avail = fullq.size() > 0;
        rbk = avail ? fullq[0] : 0;
        exp_err = 0;
        exp_valid = rd_en && avail;
        if (rd_en && avail) begin
            if (rd_addr < DP) begin
                exp_data = mem[rbk][rd_addr];
                exp_known = known[rbk][rd_addr];
            end else begin
                exp_data = '0; exp_known = 1; exp_err = 1;
            end
        end
        if (wr_en && ready) begin
            if (wr_addr < DP) begin
                mem[wbank][wr_addr] = relu_m(wr_data);
                known[wbank][wr_addr] = 1;
            end else exp_err = 1;
            if (wr_last) begin
                fullq.push_back(int'(wbank));
                wbank = !wbank;
            end
        end
        if (rd_done && avail) void'(fullq.pop_front());
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic check_all();
        chk("wr_ready", DW'(wr_ready), DW'(fullq.size() < 2));
        chk("rd_avail", DW'(rd_avail), DW'(fullq.size() > 0));
        chk("rd_valid", DW'(rd_valid), DW'(exp_valid));
        chk("err_oob", DW'(err_oob), DW'(exp_err));
        if (exp_known) chk("rd_data", rd_data, exp_data);
    endtask

    task automatic cyc(input logic we, input logic [AWD-1:0] wa, input logic [DW-1:0] wd, input logic wl,
                       input logic re, input logic [AWD-1:0] ra, input logic rd);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_last = wl;
        rd_en = re; rd_addr = ra; rd_done = rd;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        cyc(0, '0, '0, 0, 0, '0, 0);
    endtask

    task automatic fill(input logic [DW-1:0] base, input int n, input bit last);
        for (int i = 0; i < n; i++)
            cyc(1, AWD'(i), base + DW'(i), last && (i == n - 1), 0, '0, 0);
    endtask

    task automatic do_reset();
        wr_en = 0; wr_last = 0; rd_en = 0; rd_done = 0;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1;
    endtask

    initial begin
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_last = 0;
        rd_en = 0; rd_addr = '0; rd_done = 0;
        for (int b = 0; b < 2; b++) for (int a = 0; a < DP; a++) known[b][a] = 0;
        do_reset();
        chk("rst_wr_ready", DW'(wr_ready), 32'd1);
        chk("rst_rd_avail", DW'(rd_avail), 32'd0);
        chk("rst_rd_valid", DW'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_err", DW'(err_oob), 32'd0);

        fill(32'h100, DP, 1);
        chk("fill_avail", DW'(rd_avail), 32'd1);
        cyc(0, '0, '0, 0, 1, 16'd5, 0);
        chk("fill_rd5", rd_data, 32'h105);
        chk("fill_valid", DW'(rd_valid), 32'd1);
        idle();
        chk("hold_valid", DW'(rd_valid), 32'd0);
        chk("hold_data", rd_data, 32'h105);

        fill(32'h200, DP, 1);
        chk("pp_stall", DW'(wr_ready), 32'd0);
        cyc(0, '0, '0, 0, 0, '0, 1);
        chk("pp_release", DW'(wr_ready), 32'd1);
        cyc(0, '0, '0, 0, 1, 16'd7, 0);
        chk("pp_rd7", rd_data, 32'h207);

        cyc(1, 16'd64, 32'hdead_beef, 0, 0, '0, 0);
        chk("oob_wr_err", DW'(err_oob), 32'd1);
        idle();
        chk("oob_pulse", DW'(err_oob), 32'd0);
        cyc(0, '0, '0, 0, 1, 16'd70, 0);
        chk("oob_rd_data", rd_data, 32'd0);
        chk("oob_rd_valid", DW'(rd_valid), 32'd1);
        chk("oob_rd_err", DW'(err_oob), 32'd1);

        fill(32'h300, DP - 1, 0);
        cyc(1, 16'd63, 32'h33f, 1, 1, 16'd3, 1);
        chk("sim_rd3", rd_data, 32'h203);
        chk("sim_avail", DW'(rd_avail), 32'd1);
        chk("sim_ready", DW'(wr_ready), 32'd1);
        cyc(0, '0, '0, 0, 1, 16'd3, 0);
        chk("sim_new3", rd_data, 32'h303);

        cyc(0, '0, '0, 0, 0, '0, 1);
        cyc(1, 16'd0, 32'hffff_fff0, 0, 0, '0, 0);
        cyc(1, 16'd1, 32'h0000_0010, 1, 0, '0, 0);
        cyc(0, '0, '0, 0, 1, 16'd0, 0);
`ifdef ACT_BUF_RELU_EN
        chk("relu_neg", rd_data, 32'd0);
`else
        chk("relu_neg", rd_data, 32'hffff_fff0);
`endif
        cyc(0, '0, '0, 0, 1, 16'd1, 0);
        chk("relu_pos", rd_data, 32'h10);

        cyc(0, '0, '0, 0, 0, '0, 1);
        fill(32'h500, 10, 0);
        do_reset();
        chk("mid_rst_ready", DW'(wr_ready), 32'd1);
        chk("mid_rst_avail", DW'(rd_avail), 32'd0);
        chk("mid_rst_valid", DW'(rd_valid), 32'd0);
        fill(32'h400, DP, 1);
        cyc(0, '0, '0, 0, 1, 16'd9, 0);
        chk("mid_rst_rd9", rd_data, 32'h409);

        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) do_reset();
            else cyc($urandom_range(0, 9) < 6, AWD'($urandom_range(0, 69)), DW'($urandom),
                     $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                     AWD'($urandom_range(0, 67)), $urandom_range(0, 14) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
